// File: rtl/mem_responder.sv
// Memory-side responder for the sys request/ready bus.
// Clears its word array after reset, then serves one request at a time.
module mem_responder #(
  parameter int DW     = 64,
  parameter int AW     = 13,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [63:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdy,
  output logic          busy,
  output logic [31:0]   rd_cnt,
  output logic [31:0]   wr_cnt
);

  typedef enum logic [1:0] {
    INIT, IDLE, WAIT, RESP
  } state_e;

  localparam logic [3:0] RD_L = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_L = 4'(WR_LAT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rd_cnt_q, rd_cnt_d;
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic          rdy_q, busy_q;

  logic [DW-1:0] mem [2**AW];
  logic          fire;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          unused_addr;

  assign unused_addr = ^addr[63:AW];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    fire     = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = addr_q;
    mem_wd   = wdata_q;
    unique case (state_q)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        ptr_d  = ptr_q + 1'b1;
        if (&ptr_q) state_d = IDLE;
      end
      // RESP also accepts so a held req gives LAT+1 spacing
      IDLE, RESP: begin
        state_d = IDLE;
        if (req) begin
          addr_d  = addr[AW-1:0];
          wr_d    = wr;
          wdata_d = wdata;
          cnt_d   = wr ? WR_L : RD_L;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = INIT;
    endcase
    if (fire) begin
      if (wr_q) begin
        mem_we   = 1'b1;
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rdata_d  = mem[addr_q];
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rdy_q    <= (state_d == RESP);
      busy_q   <= (state_d == INIT);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rdata  = rdata_q;
  assign rdy    = rdy_q;
  assign busy   = busy_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule
